// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: owns the 24-slot operator counter, stages CPU key-on writes
// and commits them at frame start. Optional CSM auto key-on under `JT12_CSM_EN.
module jt12_kon_seq (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       kon_we,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_op,
  output logic       kon_rdy,
  input  logic       csm_en,
  input  logic       tima_over,
  output logic [4:0] slot,
  output logic       zero,
  output logic       keyon_II
);

  logic        stg_full;
  logic [2:0]  stg_chidx;
  logic [3:0]  stg_op;
  logic [23:0] kon_reg;
  logic [23:0] kon_next;
  logic [23:0] csm_mask_next;
  logic [23:0] eff_next;
  logic [2:0]  chidx;
  logic        ch_valid;
  logic        accept;
  logic        frame_edge;
  logic [4:0]  slot_next;
  logic [4:0]  base;

  assign chidx      = kon_ch[2] ? {1'b0, kon_ch[1:0]} + 3'd3 : {1'b0, kon_ch[1:0]};
  assign ch_valid   = kon_ch[1:0] != 2'd3;
  assign kon_rdy    = ~stg_full;
  assign accept     = kon_we & ~stg_full & ch_valid;
  assign frame_edge = clk_en & (slot == 5'd23);
  assign slot_next  = (slot == 5'd23) ? 5'd0 : slot + 5'd1;
  assign base       = {2'b00, stg_chidx};

  // Slot groups run S1, S3, S2, S4, so operator bits land at offsets 0, 12, 6, 18.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    kon_next = kon_reg;
    if (frame_edge && stg_full) begin
      kon_next[base]         = stg_op[0];
      kon_next[base + 5'd6]  = stg_op[2];
      kon_next[base + 5'd12] = stg_op[1];
      kon_next[base + 5'd18] = stg_op[3];
    end
  end

`ifdef JT12_CSM_EN
  logic csm_pend;
  logic csm_act;
  logic csm_act_next;

  assign csm_act_next  = frame_edge ? csm_pend : csm_act;
  assign csm_mask_next = csm_act_next ? 24'h104104 : 24'h000000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csm_pend <= 1'b0;
      csm_act  <= 1'b0;
    end else begin
      if (frame_edge) begin
        csm_act  <= csm_pend;
        csm_pend <= 1'b0;
      end
      // A pulse on the frame edge itself re-arms for the following frame.
      if (tima_over && csm_en) csm_pend <= 1'b1;
    end
  end
`else
  logic unused_csm;
  assign unused_csm    = csm_en | tima_over;
  assign csm_mask_next = 24'h000000;
`endif

  assign eff_next = kon_next | csm_mask_next;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_full  <= 1'b0;
      stg_chidx <= 3'd0;
      stg_op    <= 4'd0;
      kon_reg   <= 24'd0;
      slot      <= 5'd23;
      zero      <= 1'b0;
      keyon_II  <= 1'b0;
    end else begin
      // accept needs an empty buffer and commit needs a full one, so they never collide.
      if (accept) begin
        stg_full  <= 1'b1;
        stg_chidx <= chidx;
        stg_op    <= kon_op;
      end else if (frame_edge && stg_full) begin
        stg_full <= 1'b0;
      end
      if (clk_en) begin
        kon_reg  <= kon_next;
        slot     <= slot_next;
        zero     <= slot_next == 5'd0;
        keyon_II <= eff_next[slot_next];
      end
    end
  end

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Scoreboard bench for jt12_kon_seq; CSM expectations follow `JT12_CSM_EN.
module tb_jt12_kon_seq;

  logic       rst;
  logic       clk = 1'b0;
  logic       clk_en;
  logic       kon_we;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;
  logic       kon_rdy;
  logic       csm_en;
  logic       tima_over;
  logic [4:0] slot;
  logic       zero;
  logic       keyon_II;

  always #5 clk = ~clk;

  jt12_kon_seq dut (
    .rst       (rst),
    .clk       (clk),
    .clk_en    (clk_en),
    .kon_we    (kon_we),
    .kon_ch    (kon_ch),
    .kon_op    (kon_op),
    .kon_rdy   (kon_rdy),
    .csm_en    (csm_en),
    .tima_over (tima_over),
    .slot      (slot),
    .zero      (zero),
    .keyon_II  (keyon_II)
  );

  typedef struct {
    logic [4:0] slot;
    logic       zero;
    logic       kon;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference state, written in terms of channels and operator groups.
  bit [23:0] m_kon;
  int        m_slot;
  bit        m_zero, m_keyon, m_staged, m_pend, m_act;
  int        m_chidx;
  bit [3:0]  m_op;
  int        op_off[4] = '{0, 12, 6, 18};

`ifdef JT12_CSM_EN
  localparam logic [23:0] CSM_EXP = 24'h104104;
`else
  localparam logic [23:0] CSM_EXP = 24'h000000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kon = '0; m_slot = 23; m_zero = 0; m_keyon = 0;
    m_staged = 0; m_pend = 0; m_act = 0; m_chidx = 0; m_op = '0;
  endtask

  task automatic step(input bit ce, input bit we, input logic [2:0] ch,
                      input logic [3:0] op, input bit tima);
    exp_t e;
    bit   acc;
    int   cidx;
    @(negedge clk);
    clk_en = ce; kon_we = we; kon_ch = ch; kon_op = op; tima_over = tima;
    cidx = ch[2] ? int'(ch[1:0]) + 3 : int'(ch[1:0]);
    acc  = we && !m_staged && (ch[1:0] != 2'd3);
    if (ce && m_slot == 23) begin
      if (m_staged) begin
        for (int i = 0; i < 4; i++) m_kon[op_off[i] + m_chidx] = m_op[i];
        m_staged = 0;
      end
      m_act  = m_pend;
      m_pend = 0;
    end
    if (acc) begin
      m_staged = 1; m_chidx = cidx; m_op = op;
    end
`ifdef JT12_CSM_EN
    if (tima && csm_en) m_pend = 1;
`endif
    if (ce) begin
      m_slot  = (m_slot == 23) ? 0 : m_slot + 1;
      m_zero  = (m_slot == 0);
      m_keyon = m_kon[m_slot] | (m_act && (m_slot % 6 == 2));
    end
    e.slot = 5'(m_slot); e.zero = m_zero; e.kon = m_keyon; e.rdy = !m_staged;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("slot",     32'(slot),     32'(e.slot));
    check("zero",     32'(zero),     32'(e.zero));
    check("keyon_II", 32'(keyon_II), 32'(e.kon));
    check("kon_rdy",  32'(kon_rdy),  32'(e.rdy));
  endtask

  task automatic go_to_slot(input int s);
    int n = 0;
    while (m_slot != s && n < 200) begin
      step($urandom_range(0, 3) != 0, 0, 3'd0, 4'd0, 0);
      n++;
    end
    check("go_to_slot_bound", 32'(m_slot), 32'(s));
  endtask

  // Runs one full frame with clk_en held high and compares the key pattern seen.
  task automatic capture_frame(input logic [23:0] want, input string tag);
    logic [23:0] seen = '0;
    go_to_slot(23);
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 3'd0, 4'd0, 0);
      seen[i] = keyon_II;
    end
    check(tag, 32'(seen), 32'(want));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; kon_we = 0; tima_over = 0; clk_en = 0;
    #1;
    model_reset();
    check("rst_slot",  32'(slot),     32'd23);
    check("rst_zero",  32'(zero),     32'd0);
    check("rst_keyon", 32'(keyon_II), 32'd0);
    check("rst_rdy",   32'(kon_rdy),  32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 0; kon_we = 0; kon_ch = '0; kon_op = '0;
    csm_en = 0; tima_over = 0;
    model_reset();
    do_reset();

    // Idle frame after reset.
    capture_frame(24'h000000, "frame_idle");

    // Channel code 4 (index 3), all operators.
    go_to_slot(5);
    step(1, 1, 3'd4, 4'hF, 0);
    check("rdy_low_after_write", 32'(kon_rdy), 32'd0);
    capture_frame(24'h208208, "frame_ch4_all");

    // Write accepted on the commit edge waits a full frame.
    step(1, 1, 3'd1, 4'b0101, 0);
    check("rdy_low_commit_edge_write", 32'(kon_rdy), 32'd0);
    go_to_slot(22);
    check("rdy_still_low", 32'(kon_rdy), 32'd0);
    capture_frame(24'h20828A, "frame_ch1_s1s3");

    // Invalid channel with buffer empty, then a drop while busy, then invalid.
    go_to_slot(4);
    step(1, 1, 3'd7, 4'hF, 0);
    check("rdy_after_invalid", 32'(kon_rdy), 32'd1);
    step(1, 1, 3'd2, 4'hF, 0);
    step(1, 1, 3'd0, 4'hF, 0);
    step(1, 1, 3'd3, 4'hF, 0);
    go_to_slot(23);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 4'd0, 0);
    check("rdy_held_clk_en_low", 32'(kon_rdy), 32'd0);
    capture_frame(24'h30C38E, "frame_ch2_drops");

    // Key-off via kon_op = 0.
    go_to_slot(12);
    step(1, 1, 3'd2, 4'h0, 0);
    capture_frame(24'h20828A, "frame_ch2_off");
    go_to_slot(5);
    step(1, 1, 3'd4, 4'h0, 0);
    capture_frame(24'h000082, "frame_ch4_off");

    // CSM disabled: timer pulse ignored.
    go_to_slot(10);
    step(1, 0, 3'd0, 4'd0, 1);
    capture_frame(24'h000082, "frame_csm_off");

    // CSM enabled: channel 2 forced on for exactly one frame.
    csm_en = 1;
    go_to_slot(10);
    step(1, 0, 3'd0, 4'd0, 1);
    capture_frame(24'h000082 | CSM_EXP, "frame_csm_on");
    capture_frame(24'h000082, "frame_csm_after");
    csm_en = 0;

    // Reset mid-frame with a staged write: write lost, keys cleared.
    go_to_slot(7);
    step(1, 1, 3'd5, 4'hF, 0);
    check("rdy_low_before_reset", 32'(kon_rdy), 32'd0);
    do_reset();
    capture_frame(24'h000000, "frame_post_reset_0");
    capture_frame(24'h000000, "frame_post_reset_1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
